// File: rtl/generador_dds_pkg.sv
// Shared definitions for the DDS generator: waveform codes, quadrant type and
// the quarter-wave table generator used when the ROM is elaborated.
package generador_dds_pkg;

    localparam logic [1:0] MODE_SINE = 2'd0;
    localparam logic [1:0] MODE_TRI  = 2'd1;
    localparam logic [1:0] MODE_SQR  = 2'd2;
    localparam logic [1:0] MODE_SAW  = 2'd3;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_t;

    localparam real PI = 3.14159265358979323846;

    // round((2^(data_w-1)-1) * sin(pi/2 * i / 2^lut_aw)); the result never exceeds 2^(data_w-1)-1
    function automatic int tabla_valor(input int i, input int lut_aw, input int data_w);
        real amp;
        real ang;
        amp = real'((1 << (data_w - 1)) - 1);
        ang = (PI / 2.0) * real'(i) / real'(1 << lut_aw);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/generador_dds_tabla_cuarto_onda.sv
// Combinational quarter-wave sine ROM; contents come from the package function.
module tabla_cuarto_onda
    import generador_dds_pkg::*;
#(
    parameter int LUT_AW = 7,
    parameter int DATA_W = 8
) (
    input  logic [LUT_AW-1:0] addr,
    output logic [DATA_W-1:0] value
);

    localparam int N = 1 << LUT_AW;

    logic [DATA_W-1:0] w_rom [0:N-1];

    for (genvar g = 0; g < N; g++) begin : g_rom
        assign w_rom[g] = DATA_W'(tabla_valor(g, LUT_AW, DATA_W));
    end

    assign value = w_rom[addr];

endmodule

// File: rtl/generador_dds.sv
// DDS waveform generator: phase accumulator with wrap-synchronised step update,
// a registered phase-decode stage and a registered waveform output stage.
module generador_dds
    import generador_dds_pkg::*;
#(
    parameter int          ACC_W    = 16,
    parameter int          LUT_AW   = 7,
    parameter int          DATA_W   = 8,
    parameter int unsigned STEP_RST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [1:0]        mode,
    input  logic [ACC_W-1:0]  phase_off,
    input  logic [ACC_W-1:0]  step_in,
    input  logic              step_valid,
    output logic              step_ready,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
);

    localparam logic [DATA_W-1:0] MID  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] FULL = '1;

    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_step_act;
    logic [ACC_W-1:0]  r_step_pend;
    logic              r_pend_v;

    quadrant_t         r_q;
    logic [LUT_AW-1:0] r_idx;
    logic [DATA_W-1:0] r_s;
    logic              r_msb;
    logic [1:0]        r_mode;
    logic              r_v1;

    logic [DATA_W-1:0] r_out;
    logic              r_out_valid;

    logic [ACC_W:0]    w_sum;
    logic              w_wrap;
    logic              w_apply;
    logic              w_take;
    logic [ACC_W-1:0]  w_p;
    logic              w_unused;
    logic [LUT_AW-1:0] w_addr;
    logic [DATA_W-1:0] w_t;
    logic [DATA_W-1:0] w_sine;
    logic [DATA_W-1:0] w_sample;

    // Valid/ready: a step transfers when step_valid && step_ready; ready is low
    // while a step waits, so a transfer and an apply never share a cycle.
    assign step_ready = !r_pend_v;
    assign w_take     = step_valid && !r_pend_v;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_step_act};
    assign w_wrap  = en && !clr && w_sum[ACC_W];
    assign w_apply = r_pend_v && (w_wrap || !en || clr);

    assign w_p      = r_acc + phase_off;
    assign w_unused = ^w_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= w_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_act  <= ACC_W'(STEP_RST);
            r_step_pend <= '0;
            r_pend_v    <= 1'b0;
        end else if (w_take) begin
            r_step_pend <= step_in;
            r_pend_v    <= 1'b1;
        end else if (w_apply) begin
            r_step_act <= r_step_pend;
            r_pend_v   <= 1'b0;
        end
    end

    // Stage 1 captures every cycle; r_v1 marks whether the capture came from an advancing cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= QUAD_0;
            r_idx  <= '0;
            r_s    <= '0;
            r_msb  <= 1'b0;
            r_mode <= MODE_SINE;
            r_v1   <= 1'b0;
        end else begin
            r_q    <= quadrant_t'(w_p[ACC_W-1 -: 2]);
            r_idx  <= w_p[ACC_W-3 -: LUT_AW];
            r_s    <= w_p[ACC_W-2 -: DATA_W];
            r_msb  <= w_p[ACC_W-1];
            r_mode <= mode;
            r_v1   <= en && !clr;
        end
    end

    // Odd quadrants read the table mirrored (N-1-idx == ~idx); the lower half-period is inverted.
    assign w_addr = r_q[0] ? ~r_idx : r_idx;
    assign w_sine = r_q[1] ? (MID - 1'b1 - w_t) : (MID + w_t);

    tabla_cuarto_onda #(
        .LUT_AW (LUT_AW),
        .DATA_W (DATA_W)
    ) u_tabla (
        .addr  (w_addr),
        .value (w_t)
    );

    always_comb begin
        w_sample = w_sine;
        case (r_mode)
            MODE_SINE: w_sample = w_sine;
            MODE_TRI:  w_sample = r_msb ? (FULL - r_s) : r_s;
            MODE_SQR:  w_sample = r_msb ? '0 : FULL;
            MODE_SAW:  w_sample = {r_msb, r_s[DATA_W-1:1]};
            default:   w_sample = w_sine;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= MID;
            r_out_valid <= 1'b0;
        end else begin
            r_out       <= w_sample;
            r_out_valid <= r_v1;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_generador_dds.sv
// Scoreboard bench for generador_dds with ACC_W=16, LUT_AW=7, DATA_W=8.
module tb_generador_dds;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] phase_off = '0;
    logic [15:0] step_in = '0;
    logic        step_valid = 1'b0;
    logic        step_ready;
    logic [7:0]  out;
    logic        out_valid;

    logic [7:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;

    generador_dds #(
        .ACC_W    (16),
        .LUT_AW   (7),
        .DATA_W   (8),
        .STEP_RST (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .mode       (mode),
        .phase_off  (phase_off),
        .step_in    (step_in),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .out        (out),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid sample is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got %0d expected none", out);
            end else begin
                check("sample", int'(out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Loads a step while idle; clr zeroes the phase and the idle cycle applies it.
    task automatic load_step(input logic [15:0] v);
        en         = 1'b0;
        clr        = 1'b1;
        step_in    = v;
        step_valid = 1'b1;
        tick();
        step_valid = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic run_en(input int n);
        en = 1'b1;
        repeat (n) tick();
        en = 1'b0;
    endtask

    task automatic push(input int v);
        exp_q.push_back(8'(v));
    endtask

    initial begin
        #12;
        check("rst_out", out, 128);
        check("rst_out_valid", out_valid, 0);
        check("rst_step_ready", step_ready, 1);
        check("rst_acc", dut.r_acc, 0);
        check("rst_step_act", dut.r_step_act, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Sine, step 512: t[0]=0, t[4]=6, t[8]=12
        load_step(16'd512);
        mode = 2'd0;
        push(128); push(134); push(140);
        run_en(3);
        drain();

        // Sine at quadrant boundaries: acc 0, 16384, 32768, 49152
        load_step(16'd16384);
        push(128); push(255); push(127); push(0);
        run_en(4);
        drain();

        // Triangle, step 4096: two 16-sample periods
        load_step(16'd4096);
        mode = 2'd1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 8; i++) push(32 * i);
            for (int i = 0; i < 8; i++) push(255 - 32 * i);
        end
        run_en(32);
        drain();

        // Square then sawtooth, step 8192
        load_step(16'd8192);
        mode = 2'd2;
        for (int i = 0; i < 8; i++) push(i < 4 ? 255 : 0);
        run_en(8);
        drain();
        mode = 2'd3;
        for (int i = 0; i < 8; i++) push(32 * i);
        run_en(8);
        drain();

        // Half-period step alternates 0 and 128 on the sawtooth
        load_step(16'd32768);
        push(0); push(128); push(0); push(128);
        run_en(4);
        drain();

        // Zero step freezes the phase; the offset alone sets the sample
        load_step(16'd0);
        phase_off = 16'd4096;
        push(16); push(16); push(16);
        run_en(3);
        drain();
        check("step0_acc", dut.r_acc, 0);
        phase_off = '0;

        // Handshake: 1024 offered at acc=1024, applied at the 65024->0 wrap
        load_step(16'd512);
        mode = 2'd3;
        for (int k = 0; k < 128; k++) push(2 * k);
        push(0);
        push(4);
        en = 1'b1;
        for (int i = 0; i < 130; i++) begin
            step_valid = (i == 2);
            step_in    = 16'd1024;
            if (i == 2) check("hs_ready_offer", step_ready, 1);
            if (i == 3) check("hs_ready_drop", step_ready, 0);
            if (i == 127) begin
                check("hs_ready_prewrap", step_ready, 0);
                check("hs_acc_prewrap", dut.r_acc, 65024);
            end
            if (i == 128) begin
                check("hs_ready_rise", step_ready, 1);
                check("hs_acc_wrap", dut.r_acc, 0);
            end
            if (i == 129) check("hs_acc_newstep", dut.r_acc, 1024);
            tick();
        end
        en = 1'b0;
        step_valid = 1'b0;
        drain();

        // Offset with en low: samples flow but are not valid
        clr = 1'b1;
        tick();
        clr = 1'b0;
        mode = 2'd0;
        phase_off = 16'd16384;
        repeat (3) tick();
        check("off_out", out, 255);
        check("off_out_valid", out_valid, 0);

        // clr with en high: acc zeroed next cycle, one invalid slot two cycles later
        load_step(16'd8192);
        mode = 2'd3;
        phase_off = '0;
        push(0); push(0); push(32);
        en = 1'b1;
        tick();
        clr = 1'b1;
        tick();
        check("clr_acc", dut.r_acc, 0);
        clr = 1'b0;
        tick();
        check("clr_gap_valid", out_valid, 0);
        tick();
        en = 1'b0;
        drain();

        // Reset with a step pending discards it
        step_in = 16'd100;
        step_valid = 1'b1;
        tick();
        step_valid = 1'b0;
        check("mid_pending_ready", step_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", out, 128);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_ready", step_ready, 1);
        check("mid_rst_step_act", dut.r_step_act, 1);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_step_act", dut.r_step_act, 1);
        check("post_rst_pend_v", dut.r_pend_v, 0);
        mode = 2'd3;
        push(0); push(0); push(0);
        run_en(3);
        drain();
        check("post_rst_acc", dut.r_acc, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/generador_dds.md
# generador_dds

Parametrised direct-digital-synthesis waveform generator. A phase accumulator advances by a programmable step each enabled cycle. A quarter-wave sine table, indexed with quadrant mirroring and inversion, produces full-period sine, triangle, square or sawtooth samples. Frequency changes are double-buffered through a valid/ready handshake and take effect only at a phase wrap, so output periods are never truncated. The block drives the DAC/sample path of the lab signal chain.

## Interface
- ACC_W, 16, phase accumulator width; must satisfy ACC_W ≥ LUT_AW+2 and ACC_W ≥ DATA_W+1
- LUT_AW, 7, quarter-wave table address width (2^LUT_AW entries)
- DATA_W, 8, output sample width, offset-binary
- STEP_RST, 1, active step after reset
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  accumulator advance enable
- clr  in  1  synchronous phase clear; priority over en
- mode  in  2  waveform: 0 sine, 1 triangle, 2 square, 3 sawtooth
- phase_off  in  ACC_W  phase offset added after the accumulator; not registered
- step_in  in  ACC_W  new frequency step
- step_valid  in  1  step_in offered
- step_ready  out  1  pending slot free
- out  out  DATA_W  sample
- out_valid  out  1  out holds a sample taken from an enabled cycle

## Operation
- Registers:
  - acc (ACC_W)
  - step_act
  - step_pend
  - pend_v
  - stage-1: q (2 bits), idx (LUT_AW), s (DATA_W), msb, mode_r, v1
  - stage-2: out, out_valid
- Reset values:
  - acc = 0, step_act = STEP_RST, pend_v = 0, step_ready = 1
  - v1 = 0, out_valid = 0, out = 2^(DATA_W-1)
- Handshake:
  - step_ready = !pend_v.
  - A transfer occurs when step_valid && step_ready. The transfer loads step_pend and sets pend_v.
  - A transfer cannot coincide with an apply, because ready is low whenever pend_v is set.
- Accumulator:
  - If clr: acc <= 0.
  - Else if en: acc <= acc + step_act, modulo 2^ACC_W. wrap = carry out of this add.
  - If !en: acc holds.
- Step apply: step_act <= step_pend and pend_v <= 0 on any cycle with pend_v && (wrap || !en || clr). The new step is used from the following addition onward.
- Phase: p = acc + phase_off, modulo 2^ACC_W.
  - q = p[ACC_W-1:ACC_W-2]
  - idx = p[ACC_W-3 -: LUT_AW]
  - s = p[ACC_W-2 -: DATA_W]
  - msb = p[ACC_W-1]
- Table: t[i] = round((2^(DATA_W-1)-1)·sin(π/2·i/2^LUT_AW)), for i in 0..2^LUT_AW-1.
- Sine output by quadrant (M = 2^(DATA_W-1), N = 2^LUT_AW):
  - q0: M + t[idx]
  - q1: M + t[N-1-idx]
  - q2: M-1 − t[idx]
  - q3: M-1 − t[N-1-idx]
- Triangle: msb ? (2^DATA_W−1 − s) : s.
- Square: msb ? 0 : 2^DATA_W−1.
- Sawtooth: p[ACC_W-1 -: DATA_W].
- mode is sampled into stage 1. A mode change affects only samples whose stage-1 capture follows the change; there is no partial-sample mixing.
- clr does not flush the pipeline. Samples already in stage 1 and stage 2 complete normally.

## Timing
- Latency: 2 cycles. The acc and phase_off values at cycle t appear on out at cycle t+2.
- v1 <= en && !clr; out_valid <= v1. When out_valid = 0, out holds its last value.
- Step apply on wrap: the add on the wrap cycle uses the old step. The next add uses the new step.
- rst_n asserted mid-operation: all registers return to reset values immediately (asynchronous). A pending step is discarded.
- Full-scale step values are legal:
  - step 0: acc frozen while en.
  - step 2^(ACC_W-1): alternates 0 and half-period.
  - Any step wraps modulo 2^ACC_W.

## Structure
- Package generador_dds_pkg holds:
  - waveform mode constants (MODE_SINE, MODE_TRI, MODE_SQR, MODE_SAW)
  - the quadrant type
  - a function computing t[i] for table elaboration
- Sub-module tabla_cuarto_onda: combinational quarter-wave ROM, parameters LUT_AW and DATA_W, port addr → value, filled at elaboration from the package function.
- Everything else stays in generador_dds.

## Test plan
All cases use ACC_W=16, LUT_AW=7, DATA_W=8.
- Sine: reset, en=1, step 512 (default via handshake), mode 0 → out sequence from first valid: 128, 134 (t[4]=6), …; acc=16384 yields 255, acc=32768 yields 127.
- Triangle: step 4096, mode 1 → 0, 32, 64 … 224, then 255, 223 … 31, repeating every 16 samples.
- Square and sawtooth: step 8192, mode 2 → 255 for four samples then 0 for four; mode 3 → 0, 32, 64 … 224.
- Handshake: step 512 running; offer 1024 at acc=1024 → step_ready drops the next cycle; adds continue at 512 until wrap (acc 65024→0); the next acc is 1024; step_ready rises the cycle after apply.
- Offset, en and clr: en=0, acc=0, phase_off=16384, sine → out 255 with out_valid=0; clr with en=1 → acc=0 the next cycle and out_valid low 2 cycles later for one cycle.
- Reset mid-run: assert rst_n low with pend_v=1 → out=128, out_valid=0, step_ready=1, step_act=1 immediately; after release the step is 1 and the pending value is lost.
